// File: rtl/cyclic_decoder_seq.sv
// Serial syndrome decoder for a systematic binary cyclic code (N,K); corrects one bit error by error trapping.
// Latency: N+1+t cycles from accept to o_Valid (t = trap shift count); 2N cycles when CYCDEC_FIXED_LATENCY_EN is defined.
// Backpressure: one word in flight; o_Ready low from accept until result handed off; results held while i_Ready is low.
module cyclic_decoder_seq #(
    parameter int            N        = 15,
    parameter int            K        = 7,
    parameter logic [N-K:0]  GEN_POLY = 9'b111010001
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [N-1:0]          i_CodeWord,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [K-1:0]          o_DecodWord,
    output logic [N-K-1:0]        o_Syndrome,
    output logic [$clog2(N)-1:0]  o_ErrPos,
    output logic                  o_ErrorC,
    output logic                  o_ErrorD
);

    localparam int              R    = N - K;
    localparam int              CW   = $clog2(N);
    localparam logic [CW-1:0]   LAST = CW'(N - 1);
    localparam logic [R-1:0]    POLY = GEN_POLY[R-1:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYND   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N-1:0]    word;
    logic [R-1:0]    syn;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   t;

    logic [R-1:0]    syn_step;
    logic [R-1:0]    syn_mulx;
    logic            zero_hit;
    logic            one_hit;
    logic [CW:0]     pos_wide;
    logic [CW-1:0]   err_pos;
    logic [K-1:0]    msg_mask;
    logic            search_done;

`ifdef CYCDEC_FIXED_LATENCY_EN
    logic            captured;
`endif

    // Syndrome LFSR step, trap test and error-position arithmetic
    always_comb begin
        syn_step = {syn[R-2:0], word[cnt]} ^ (syn[R-1] ? POLY : '0);
        syn_mulx = {syn[R-2:0], 1'b0}      ^ (syn[R-1] ? POLY : '0);
        zero_hit = (t == '0) && (syn == '0);
        one_hit  = (syn == R'(1));
        // After t shifts the trapped single error sits at bit (N-t) mod N
        pos_wide = (t == '0) ? '0 : ((CW+1)'(N) - {1'b0, t});
        err_pos  = pos_wide[CW-1:0];
        // Parity-bit errors leave the message untouched
        msg_mask = (32'(err_pos) >= R) ? (K'(1) << (32'(err_pos) - R)) : '0;
`ifdef CYCDEC_FIXED_LATENCY_EN
        search_done = (t == LAST);
`else
        search_done = zero_hit || one_hit || (t == LAST);
`endif
    end

    // FSM state register
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_Ready   = 1'b0;
        o_Valid   = 1'b0;
        case (state)
            IDLE: begin
                o_Ready = 1'b1;
                if (i_Valid) begin
                    state_nxt = SYND;
                end
            end
            SYND: begin
                if (cnt == '0) begin
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (search_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_Valid = 1'b1;
                if (i_Ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: word latch, serial syndrome, trap search and result registers
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            word        <= '0;
            syn         <= '0;
            cnt         <= '0;
            t           <= '0;
            o_DecodWord <= '0;
            o_Syndrome  <= '0;
            o_ErrPos    <= '0;
            o_ErrorC    <= 1'b0;
            o_ErrorD    <= 1'b0;
`ifdef CYCDEC_FIXED_LATENCY_EN
            captured    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_Valid) begin
                        word <= i_CodeWord;
                        syn  <= '0;
                        cnt  <= LAST;
                        t    <= '0;
`ifdef CYCDEC_FIXED_LATENCY_EN
                        captured <= 1'b0;
`endif
                    end
                end
                SYND: begin
                    syn <= syn_step;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        o_Syndrome <= syn_step;
                        t          <= '0;
                    end
                end
                SEARCH: begin
`ifdef CYCDEC_FIXED_LATENCY_EN
                    // Run the full N-step search; only the first hit is kept
                    if (!captured && zero_hit) begin
                        captured    <= 1'b1;
                        o_DecodWord <= word[N-1:R];
                        o_ErrPos    <= '0;
                        o_ErrorC    <= 1'b0;
                        o_ErrorD    <= 1'b0;
                    end else if (!captured && one_hit) begin
                        captured    <= 1'b1;
                        o_DecodWord <= word[N-1:R] ^ msg_mask;
                        o_ErrPos    <= err_pos;
                        o_ErrorC    <= 1'b1;
                        o_ErrorD    <= 1'b0;
                    end else if (!captured && (t == LAST)) begin
                        o_DecodWord <= word[N-1:R];
                        o_ErrPos    <= '0;
                        o_ErrorC    <= 1'b0;
                        o_ErrorD    <= 1'b1;
                    end
                    syn <= syn_mulx;
                    if (t != LAST) begin
                        t <= t + 1'b1;
                    end
`else
                    if (zero_hit) begin
                        o_DecodWord <= word[N-1:R];
                        o_ErrPos    <= '0;
                        o_ErrorC    <= 1'b0;
                        o_ErrorD    <= 1'b0;
                    end else if (one_hit) begin
                        o_DecodWord <= word[N-1:R] ^ msg_mask;
                        o_ErrPos    <= err_pos;
                        o_ErrorC    <= 1'b1;
                        o_ErrorD    <= 1'b0;
                    end else if (t == LAST) begin
                        o_DecodWord <= word[N-1:R];
                        o_ErrPos    <= '0;
                        o_ErrorC    <= 1'b0;
                        o_ErrorD    <= 1'b1;
                    end else begin
                        syn <= syn_mulx;
                        t   <= t + 1'b1;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cyclic_decoder_seq.sv
module tb_cyclic_decoder_seq;

    localparam int N  = 15;
    localparam int K  = 7;
    localparam int R  = N - K;
    localparam int PW = $clog2(N);

`ifdef CYCDEC_FIXED_LATENCY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          i_Clk = 1'b0;
    logic          i_Rst_n = 1'b0;
    logic          i_Valid = 1'b0;
    logic          o_Ready;
    logic [N-1:0]  i_CodeWord = '0;
    logic          o_Valid;
    logic          i_Ready = 1'b0;
    logic [K-1:0]  o_DecodWord;
    logic [R-1:0]  o_Syndrome;
    logic [PW-1:0] o_ErrPos;
    logic          o_ErrorC;
    logic          o_ErrorD;

    int checks = 0;
    int errors = 0;
    int lat;
    int vld_seen;

    cyclic_decoder_seq #(.N(N), .K(K), .GEN_POLY(9'b111010001)) dut (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Valid    (i_Valid),
        .o_Ready    (o_Ready),
        .i_CodeWord (i_CodeWord),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_DecodWord(o_DecodWord),
        .o_Syndrome (o_Syndrome),
        .o_ErrPos   (o_ErrPos),
        .o_ErrorC   (o_ErrorC),
        .o_ErrorD   (o_ErrorD)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic int exp_lat(input int early);
        return FIXED ? 2 * N : early;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present a word, confirm acceptance, then count edges until o_Valid
    task automatic start_word(input string tag, input logic [N-1:0] cw, input int want_lat);
        i_CodeWord = cw;
        i_Valid    = 1'b1;
        check({tag, "_ready_idle"}, 32'(o_Ready), 32'd1);
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        check({tag, "_ready_busy"}, 32'(o_Ready), 32'd0);
        lat = 0;
        while (o_Valid !== 1'b1 && lat < 100) begin
            @(posedge i_Clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(want_lat));
    endtask

    task automatic check_result(input string tag, input logic [K-1:0] dec, input logic [R-1:0] syn,
                                input logic [PW-1:0] pos, input logic c, input logic d);
        check({tag, "_decod"}, 32'(o_DecodWord), 32'(dec));
        check({tag, "_synd"},  32'(o_Syndrome),  32'(syn));
        check({tag, "_pos"},   32'(o_ErrPos),    32'(pos));
        check({tag, "_errc"},  32'(o_ErrorC),    32'(c));
        check({tag, "_errd"},  32'(o_ErrorD),    32'(d));
    endtask

    task automatic pop(input string tag);
        i_Ready = 1'b1;
        @(posedge i_Clk); #1;
        i_Ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(o_Valid), 32'd0);
        check({tag, "_ready_back"}, 32'(o_Ready), 32'd1);
    endtask

    initial begin
        // Reset
        i_Rst_n = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        check("rst_ready", 32'(o_Ready), 32'd1);
        check("rst_valid", 32'(o_Valid), 32'd0);
        check_result("rst", 7'h00, 8'h00, 4'd0, 1'b0, 1'b0);
        i_Rst_n = 1'b1;
        @(posedge i_Clk); #1;

        // Clean codeword (message 1, parity = g(x) remainder)
        start_word("clean", 15'h01D1, exp_lat(16));
        check_result("clean", 7'h01, 8'h00, 4'd0, 1'b0, 1'b0);
        pop("clean");

        // Bit 14 flipped, then held in DONE under backpressure
        start_word("b14", 15'h41D1, exp_lat(17));
        check_result("b14", 7'h01, 8'hE8, 4'd14, 1'b1, 1'b0);
        i_Valid    = 1'b1;
        i_CodeWord = 15'h00D1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_Clk); #1;
            check("bp_valid", 32'(o_Valid), 32'd1);
            check("bp_ready", 32'(o_Ready), 32'd0);
            check("bp_decod", 32'(o_DecodWord), 32'h01);
            check("bp_pos",   32'(o_ErrPos), 32'd14);
            check("bp_synd",  32'(o_Syndrome), 32'hE8);
        end
        pop("b14");

        // Next word accepted on the cycle after release: bit 8 flipped
        start_word("b8", 15'h00D1, exp_lat(23));
        check_result("b8", 7'h01, 8'hD1, 4'd8, 1'b1, 1'b0);
        pop("b8");

        // Bit 0 flipped (parity error, message unchanged)
        start_word("b0", 15'h01D0, exp_lat(16));
        check_result("b0", 7'h01, 8'h01, 4'd0, 1'b1, 1'b0);
        pop("b0");

        // Bits 0 and 1 flipped: detected, not corrected
        start_word("dbl", 15'h01D2, exp_lat(30));
        check_result("dbl", 7'h01, 8'h03, 4'd0, 1'b0, 1'b1);
        pop("dbl");

        // Reset in the middle of syndrome computation
        i_CodeWord = 15'h41D1;
        i_Valid    = 1'b1;
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        repeat (5) @(posedge i_Clk);
        #1;
        check("mid_busy", 32'(o_Ready), 32'd0);
        i_Rst_n = 1'b0;
        @(posedge i_Clk); #1;
        i_Rst_n = 1'b1;
        check("mid_ready", 32'(o_Ready), 32'd1);
        check("mid_valid", 32'(o_Valid), 32'd0);
        check_result("mid", 7'h00, 8'h00, 4'd0, 1'b0, 1'b0);
        vld_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_Clk); #1;
            if (o_Valid === 1'b1) vld_seen++;
        end
        check("mid_no_valid", 32'(vld_seen), 32'd0);

        // Recovery after aborted word
        start_word("rec", 15'h01D0, exp_lat(16));
        check_result("rec", 7'h01, 8'h01, 4'd0, 1'b1, 1'b0);
        pop("rec");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cyclic_decoder_seq.md
Name: cyclic_decoder_seq

Overview:
- Parametrised, multi-cycle syndrome decoder for systematic binary cyclic codes (N,K), default BCH(15,7) with g(x)=x^8+x^7+x^6+x^4+1.
- Computes the syndrome serially with an LFSR, then runs a cyclic error-trapping search to locate and correct one bit error; larger nonzero syndromes are flagged as detected-uncorrectable.
- Sits between the channel/word buffer and the data consumer, with valid/ready handshakes on both sides.

Parameters:
- N, 15, codeword length in bits (3..255).
- K, 7, message length; R=N-K is the syndrome width.
- GEN_POLY, 9'b111010001, generator polynomial [R:0], MSB = x^R; GEN_POLY[R]=GEN_POLY[0]=1, and g(x) must divide x^N+1.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst_n  in  1  synchronous active-low reset.
- i_Valid  in  1  input codeword valid.
- o_Ready  out  1  decoder can accept a codeword.
- i_CodeWord  in  N  codeword; [N-1:R] = message, [R-1:0] = parity.
- o_Valid  out  1  result valid.
- i_Ready  in  1  consumer accepts result.
- o_DecodWord  out  K  corrected message, corrected[N-1:R].
- o_Syndrome  out  R  raw syndrome of the received word.
- o_ErrPos  out  $clog2(N)  corrected bit index; 0 when o_ErrorC=0.
- o_ErrorC  out  1  single error corrected.
- o_ErrorD  out  1  uncorrectable error detected; o_DecodWord is the uncorrected message.

Behaviour:
- Reset (i_Rst_n=0 at a clock edge):
  - State -> IDLE; all outputs and registers -> 0, except o_Ready=1 once in IDLE.
  - Reset mid-operation aborts the word; no o_Valid is issued for it.
- FSM states: IDLE, SYND, SEARCH, DONE.
- IDLE:
  - o_Ready=1.
  - On i_Valid&&o_Ready (accept edge E0): latch i_CodeWord, syndrome s<=0, bit counter<=N-1 -> SYND.
- SYND: one bit per cycle, MSB first.
  - Per bit: s <= {s[R-2:0],bit} ^ (s[R-1] ? GEN_POLY[R-1:0] : 0).
  - Runs exactly N cycles (edges E1..EN), then -> SEARCH with shift count t=0.
  - o_Syndrome is registered at EN.
- SEARCH: one check per cycle.
  - s==0 at t=0: no error. Corrected = latched word, flags 0 -> DONE.
  - Else if s==1: error position j=(t==0)?0:N-t. Corrected = word ^ (1<<j), o_ErrorC=1, o_ErrPos=j -> DONE.
  - Else if t==N-1: o_ErrorD=1, corrected = word -> DONE.
  - Else s <= mulx(s) (the same shift with a 0 input bit), t<=t+1.
- Latency: o_Valid rises after edge E(N+1+t).
  - No error: N+1 cycles after accept.
  - Error at bit j: N+1+((N-j) mod N) cycles.
  - Uncorrectable: 2N cycles.
- DONE:
  - o_Valid=1; all result outputs stable while i_Ready=0, with no timeout.
  - On o_Valid&&i_Ready -> IDLE; o_Valid drops and o_Ready rises on the same edge.
- o_Ready=0 in SYND, SEARCH and DONE; i_Valid is ignored outside IDLE.
- Counters use width $clog2(N); t never wraps past N-1.
- Results are exclusive: at most one of o_ErrorC and o_ErrorD is 1 per word.

Optional Feature:
- Macro: CYCDEC_FIXED_LATENCY_EN.
- Defined:
  - SEARCH always runs N cycles (t=0..N-1). The first s==1 or s==0 hit is captured into result registers and later cycles do not alter them.
  - ErrorD is decided only at t=N-1.
  - o_Valid is always 2N cycles after accept, giving data-independent timing.
- Undefined: early-exit behaviour described above.

Test Plan:
- Reset, then clean word 15'h01D1 (msg 7'b0000001) -> o_Valid 16 cycles after accept; DecodWord=7'h01, Syndrome=8'h00, ErrorC=0, ErrorD=0.
- 15'h41D1 (bit 14 flipped) -> o_Valid at 17 cycles; DecodWord=7'h01, Syndrome=8'hE8, ErrPos=14, ErrorC=1. Then 15'h01D0 (bit 0) -> Syndrome=8'h01, ErrPos=0, o_Valid at 16 cycles.
- 15'h00D1 (bit 8 flipped) -> Syndrome=8'hD1, ErrPos=8, DecodWord=7'h01, o_Valid at 23 cycles.
- 15'h01D2 (bits 0 and 1 flipped) -> Syndrome=8'h03, ErrorD=1, ErrorC=0, DecodWord=7'h01, o_Valid at 30 cycles.
- Backpressure: hold i_Ready=0 for 5 cycles in DONE -> outputs stable, o_Ready=0, extra i_Valid ignored; on release, accept the next word on the following cycle.
- Assert i_Rst_n=0 during SYND (cycle 6) -> IDLE next edge, all outputs 0, no o_Valid. With CYCDEC_FIXED_LATENCY_EN, repeat the first two scenarios -> o_Valid at 30 cycles in both.
